// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared pipeline types for the RV64 core
package pipeline_pkg;
   localparam int XLEN = 64;

   typedef struct packed {
      logic [31:0]     instr;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] pcPlus4;
   } ifid_t;
endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - RV64 fetch front end: PC owner, in-order imem requests, instruction FIFO
// Define FETCH_BYPASS_EN to forward a response straight to ifid_o while the FIFO is empty.
module fetch_queue
   import pipeline_pkg::*;
#(
   parameter int              XLEN     = pipeline_pkg::XLEN,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            reset,
   output logic            imem_req_o,
   output logic [XLEN-1:0] imem_addr_o,
   input  logic            imem_ready_i,
   input  logic            imem_rvalid_i,
   input  logic [31:0]     imem_rdata_i,
   input  logic            redirect_i,
   input  logic [XLEN-1:0] redirect_pc_i,
   output logic            ifid_valid_o,
   input  logic            ifid_ready_i,
   output ifid_t           ifid_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [XLEN-1:0] pc;
   ifid_t           fifoMem [DEPTH];
   logic [XLEN-1:0] tagMem  [DEPTH];
   logic [AW-1:0]   fifoWrPtr;
   logic [AW-1:0]   fifoRdPtr;
   logic [AW-1:0]   tagWrPtr;
   logic [AW-1:0]   tagRdPtr;
   logic [CW-1:0]   count;
   logic [CW-1:0]   outstanding;
   logic [CW-1:0]   dropCnt;

   logic [CW:0]     credit;
   logic            issue;
   logic            respKeep;
   logic            bypassValid;
   logic            bypassTake;
   logic            push;
   logic            pop;
   logic            fifoNotEmpty;
   logic [XLEN-1:0] tagPc;
   ifid_t           respEntry;
   logic            unusedRedirectLsbs;

   assign unusedRedirectLsbs = ^redirect_pc_i[1:0];

   // Buffered plus in-flight instructions never exceed DEPTH, so a response always has a slot.
   assign credit     = {1'b0, count} + {1'b0, outstanding};
   assign imem_req_o = ~reset & ~redirect_i & (credit < (CW+1)'(DEPTH));
   assign imem_addr_o = pc;
   assign issue      = imem_req_o & imem_ready_i;

   // Wrong-path responses are swallowed while dropCnt is non-zero or a redirect is in progress.
   assign respKeep   = imem_rvalid_i & (dropCnt == '0) & ~redirect_i & ~reset;
   assign tagPc      = tagMem[tagRdPtr];

   always_comb begin
      respEntry         = '0;
      respEntry.instr   = imem_rdata_i;
      respEntry.pc      = tagPc;
      respEntry.pcPlus4 = tagPc + XLEN'(4);
   end

   assign fifoNotEmpty = (count != '0);

`ifdef FETCH_BYPASS_EN
   assign bypassValid = respKeep & ~fifoNotEmpty;
`else
   assign bypassValid = 1'b0;
`endif

   assign ifid_valid_o = ~reset & (fifoNotEmpty | bypassValid);
   assign bypassTake   = bypassValid & ifid_ready_i;
   assign pop          = ~reset & fifoNotEmpty & ifid_ready_i;
   assign push         = respKeep & ~bypassTake;

   always_comb begin
      ifid_o = '0;
      if (!reset) begin
         if (fifoNotEmpty) begin
            ifid_o = fifoMem[fifoRdPtr];
         end else if (bypassValid) begin
            ifid_o = respEntry;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc          <= RESET_PC;
         fifoWrPtr   <= '0;
         fifoRdPtr   <= '0;
         tagWrPtr    <= '0;
         tagRdPtr    <= '0;
         count       <= '0;
         outstanding <= '0;
         dropCnt     <= '0;
      end else begin
         outstanding <= outstanding + CW'(issue) - CW'(imem_rvalid_i);
         if (redirect_i) begin
            // Everything still in flight belongs to the old path, including responses already being dropped.
            pc        <= {redirect_pc_i[XLEN-1:2], 2'b00};
            fifoWrPtr <= '0;
            fifoRdPtr <= '0;
            tagWrPtr  <= '0;
            tagRdPtr  <= '0;
            count     <= '0;
            dropCnt   <= outstanding - CW'(imem_rvalid_i);
         end else begin
            if (issue) begin
               pc       <= pc + XLEN'(4);
               tagWrPtr <= tagWrPtr + 1'b1;
            end
            if (imem_rvalid_i) begin
               if (dropCnt != '0) begin
                  dropCnt <= dropCnt - 1'b1;
               end else begin
                  tagRdPtr <= tagRdPtr + 1'b1;
               end
            end
            if (push) begin
               fifoWrPtr <= fifoWrPtr + 1'b1;
            end
            if (pop) begin
               fifoRdPtr <= fifoRdPtr + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
         end
      end
   end

   // Storage arrays need no reset; the pointers and counters define what is live.
   always_ff @(posedge clk) begin
      if (issue) begin
         tagMem[tagWrPtr] <= pc;
      end
      if (push) begin
         fifoMem[fifoWrPtr] <= respEntry;
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - scoreboard bench for fetch_queue with an in-order variable-latency memory model
module tb_fetch_queue;
   import pipeline_pkg::*;

   localparam logic [63:0] RESET_PC = 64'h1000;
   localparam int          DEPTH    = 4;
`ifdef FETCH_BYPASS_EN
   localparam int          EXP_LAT  = 1;
`else
   localparam int          EXP_LAT  = 2;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req_o;
   logic [63:0] imem_addr_o;
   logic        imem_ready_i;
   logic        imem_rvalid_i;
   logic [31:0] imem_rdata_i;
   logic        redirect_i;
   logic [63:0] redirect_pc_i;
   logic        ifid_valid_o;
   logic        ifid_ready_i;
   ifid_t       ifid_o;

   always #5 clk = ~clk;

   fetch_queue #(.XLEN(64), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk          (clk),
      .reset        (reset),
      .imem_req_o   (imem_req_o),
      .imem_addr_o  (imem_addr_o),
      .imem_ready_i (imem_ready_i),
      .imem_rvalid_i(imem_rvalid_i),
      .imem_rdata_i (imem_rdata_i),
      .redirect_i   (redirect_i),
      .redirect_pc_i(redirect_pc_i),
      .ifid_valid_o (ifid_valid_o),
      .ifid_ready_i (ifid_ready_i),
      .ifid_o       (ifid_o)
   );

   typedef struct {
      logic [63:0] addr;
      int          due;
   } memReq_t;

   int      compared   = 0;
   int      mismatched = 0;
   int      cyc        = 0;
   int      memLat     = 1;
   int      lastDelivCyc = 0;
   ifid_t   expQ[$];
   memReq_t pend[$];
   ifid_t   monExp;

   function automatic logic [31:0] instrOf(input logic [63:0] a);
      return {a[17:2], 16'h0013};
   endfunction

   task automatic pushExp(input logic [63:0] p, input logic [63:0] p4);
      ifid_t e;
      e.instr   = instrOf(p);
      e.pc      = p;
      e.pcPlus4 = p4;
      expQ.push_back(e);
   endtask

   task automatic pushRun(input logic [63:0] start, input int n);
      for (int i = 0; i < n; i++) pushExp(start + 64'(4*i), start + 64'(4*i+4));
   endtask

   task automatic chk(input string name, input logic [159:0] act, input logic [159:0] req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic doReset(input int n);
      reset = 1'b1;
      repeat (n) tick();
      reset = 1'b0;
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while (expQ.size() != 0 && n < budget) begin
         tick();
         n++;
      end
      if (expQ.size() != 0) begin
         compared++;
         mismatched++;
         $display("FAIL drain_timeout: %0d entries undelivered, required 0", expQ.size());
         expQ.delete();
      end
      ifid_ready_i = 1'b0;
   endtask

   task automatic waitHandshakes(input int want);
      int hs = 0;
      int n  = 0;
      while (hs < want && n < 50) begin
         @(negedge clk);
         if (imem_req_o && imem_ready_i) hs++;
         n++;
      end
      if (hs < want) begin
         compared++;
         mismatched++;
         $display("FAIL handshake_timeout: got %0d, required %0d", hs, want);
      end
   endtask

   // Memory: in-order responses memLat cycles after each accepted request; cleared by reset.
   initial begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = '0;
      forever begin
         @(posedge clk);
         cyc++;
         #2;
         if (reset) begin
            pend.delete();
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = '0;
         end else if (pend.size() > 0 && pend[0].due <= cyc) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = instrOf(pend[0].addr);
            void'(pend.pop_front());
         end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = '0;
         end
         @(negedge clk);
         if (!reset && imem_req_o && imem_ready_i) pend.push_back('{imem_addr_o, cyc + memLat});
      end
   end

   // Monitor: a redirect cycle's handshake is killed by FlushD, so it is not a delivery.
   initial begin
      forever begin
         @(negedge clk);
         if (!reset) begin
            if (imem_rvalid_i) chk("credit_full_plus_rvalid", 160'(dut.count == 3'(DEPTH)), 160'(0));
            if (!ifid_valid_o) begin
               chk("ifid_zero_when_invalid", ifid_o, '0);
            end else if (ifid_ready_i && !redirect_i) begin
               lastDelivCyc = cyc;
               if (expQ.size() == 0) begin
                  compared++;
                  mismatched++;
                  $display("FAIL unexpected_delivery: got pc %h, required none", ifid_o.pc);
               end else begin
                  monExp = expQ.pop_front();
                  chk("ifid_delivery", ifid_o, monExp);
               end
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int          reqCyc;
      int          valCyc;
      int          n;
      logic        prevStall;
      logic [63:0] prevAddr;

      reset         = 1'b1;
      redirect_i    = 1'b0;
      redirect_pc_i = '0;
      ifid_ready_i  = 1'b0;
      imem_ready_i  = 1'b1;
      tick();
      @(negedge clk);
      chk("reset_req", 160'(imem_req_o), 160'(0));
      chk("reset_valid", 160'(ifid_valid_o), 160'(0));
      chk("reset_ifid", ifid_o, '0);
      tick();

      // Streaming from RESET_PC with a 1-cycle memory, plus first-valid latency.
      memLat = 1;
      pushRun(RESET_PC, 12);
      ifid_ready_i = 1'b1;
      reset  = 1'b0;
      reqCyc = -1;
      valCyc = -1;
      for (int i = 0; i < 20 && valCyc < 0; i++) begin
         @(negedge clk);
         if (reqCyc < 0 && imem_req_o && imem_ready_i) reqCyc = cyc;
         if (valCyc < 0 && ifid_valid_o) valCyc = cyc;
      end
      chk("first_req_addr_cycle_seen", 160'(reqCyc >= 0), 160'(1));
      chk("first_valid_latency", 160'(valCyc - reqCyc), 160'(EXP_LAT));
      tick();
      drain(100);
      chk("stream_one_per_cycle", 160'(lastDelivCyc - valCyc), 160'(11));

      // Consumer stall: FIFO fills, requests stop, nothing lost.
      doReset(2);
      pushRun(RESET_PC, 10);
      repeat (10) tick();
      @(negedge clk);
      chk("stall_count_full", 160'(dut.count), 160'(4));
      chk("stall_req_low", 160'(imem_req_o), 160'(0));
      chk("stall_valid_high", 160'(ifid_valid_o), 160'(1));
      tick();
      ifid_ready_i = 1'b1;
      drain(100);

      // Redirect with three responses in flight on a 3-cycle memory.
      doReset(2);
      memLat = 3;
      waitHandshakes(3);
      tick();
      pushRun(64'h2000, 8);
      redirect_i    = 1'b1;
      redirect_pc_i = 64'h2003;
      ifid_ready_i  = 1'b1;
      @(negedge clk);
      chk("redirect_cycle_no_req", 160'(imem_req_o), 160'(0));
      tick();
      redirect_i = 1'b0;
      @(negedge clk);
      chk("redirect_next_req", 160'(imem_req_o), 160'(1));
      chk("redirect_next_addr", 160'(imem_addr_o), 160'(64'h2000));
      tick();
      drain(200);

      // Two redirects with old-path and 0x3000 responses still in flight.
      doReset(2);
      memLat = 3;
      waitHandshakes(2);
      tick();
      redirect_i    = 1'b1;
      redirect_pc_i = 64'h3000;
      tick();
      redirect_i = 1'b0;
      @(negedge clk);
      chk("redirect_a_addr", 160'(imem_addr_o), 160'(64'h3000));
      tick();
      pushRun(64'h4000, 6);
      redirect_i    = 1'b1;
      redirect_pc_i = 64'h4000;
      ifid_ready_i  = 1'b1;
      tick();
      redirect_i = 1'b0;
      drain(200);

      // imem_ready toggling: address held while stalled, no duplicates or gaps.
      doReset(2);
      memLat       = 1;
      ifid_ready_i = 1'b1;
      pushRun(RESET_PC, 10);
      prevStall = 1'b0;
      prevAddr  = '0;
      n = 0;
      while (n < 100) begin
         tick();
         if (expQ.size() == 0) break;
         imem_ready_i = !imem_ready_i;
         @(negedge clk);
         if (prevStall && imem_req_o) chk("addr_hold_while_not_ready", 160'(imem_addr_o), 160'(prevAddr));
         prevStall = imem_req_o && !imem_ready_i;
         prevAddr  = imem_addr_o;
         n++;
      end
      if (expQ.size() != 0) begin
         compared++;
         mismatched++;
         $display("FAIL toggle_timeout: %0d entries undelivered, required 0", expQ.size());
         expQ.delete();
      end
      ifid_ready_i = 1'b0;
      imem_ready_i = 1'b1;

      // Mid-operation reset with buffered entries and requests outstanding.
      doReset(2);
      memLat = 3;
      repeat (4) tick();
      @(negedge clk);
      chk("pre_reset_valid", 160'(ifid_valid_o), 160'(1));
      tick();
      reset = 1'b1;
      @(negedge clk);
      chk("midreset_req", 160'(imem_req_o), 160'(0));
      chk("midreset_valid", 160'(ifid_valid_o), 160'(0));
      tick();
      pushRun(RESET_PC, 4);
      ifid_ready_i = 1'b1;
      reset = 1'b0;
      @(negedge clk);
      chk("post_reset_valid", 160'(ifid_valid_o), 160'(0));
      chk("post_reset_addr", 160'(imem_addr_o), 160'(RESET_PC));
      tick();
      drain(200);

      // PC wrap at the top of the address space; redirect low bits ignored.
      doReset(2);
      memLat = 1;
      tick();
      tick();
      pushExp(64'hFFFF_FFFF_FFFF_FFFC, 64'h0);
      pushExp(64'h0, 64'h4);
      pushExp(64'h4, 64'h8);
      redirect_i    = 1'b1;
      redirect_pc_i = 64'hFFFF_FFFF_FFFF_FFFF;
      ifid_ready_i  = 1'b1;
      tick();
      redirect_i = 1'b0;
      drain(100);

      doReset(1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
